decode_regfile_pipe: RTL and testbench

- Parametrised decode stage for the lightbike CPU pipeline: register file, 2 read ports, 1 writeback port, instruction field decode, and an output pipeline register with stall/flush control.
- Sits between fetch and execute.
- Adds write-through bypass, stall-hold with operand refresh, flush bubbles, and configurable data width and register count.

---
 rtl/decode_regfile_pipe_if.sv | 68 ++++++
 rtl/decode_regfile_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_decode_regfile_pipe.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_regfile_pipe_if.sv
// -----------------------------------------------------------------------------
// decode_regfile_pipe_if
//
// Bundles the fetch-side instruction handshake, the writeback port and the
// registered decode outputs of decode_regfile_pipe.
//
// Handshake semantics: the fetch side presents 'instruction' qualified by
// 'in_valid'. There is no ready signal. When 'stall' is high, the decode
// output register holds its contents and the presented instruction is not
// consumed. 'flush' squashes whatever would enter the output register on that
// edge. 'out_valid' marks a live instruction in the output register.
//
// Modports
//   master : fetch/writeback driver (drives inputs, observes decode outputs)
//   slave  : the decode stage itself
//
// Signals
//   in_valid, instruction[31:0]        fetched instruction and its qualifier
//   stall, flush                       pipeline control
//   wb_en, wb_rd[4:0], wb_data         writeback port
//   out_valid, A, B                    registered operands
//   j1en j2en ren_out men ben exen     registered control enables
//   aluop, shamt, rd_out               registered decoded fields
//   immediate[16:0], target[26:0]      registered immediates
//   perf_issued, perf_stalled          performance counters (zero if disabled)
// -----------------------------------------------------------------------------
interface decode_regfile_pipe_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [31:0]       instruction;
    logic              stall;
    logic              flush;
    logic              wb_en;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;

    logic              out_valid;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              j1en;
    logic              j2en;
    logic              ren_out;
    logic              men;
    logic              ben;
    logic              exen;
    logic [4:0]        aluop;
    logic [4:0]        shamt;
    logic [4:0]        rd_out;
    logic [16:0]       immediate;
    logic [26:0]       target;
    logic [31:0]       perf_issued;
    logic [31:0]       perf_stalled;

    modport master (
        output in_valid, instruction, stall, flush, wb_en, wb_rd, wb_data,
        input  out_valid, A, B, j1en, j2en, ren_out, men, ben, exen,
               aluop, shamt, rd_out, immediate, target,
               perf_issued, perf_stalled
    );

    modport slave (
        input  in_valid, instruction, stall, flush, wb_en, wb_rd, wb_data,
        output out_valid, A, B, j1en, j2en, ren_out, men, ben, exen,
               aluop, shamt, rd_out, immediate, target,
               perf_issued, perf_stalled
    );
endinterface

// File: rtl/decode_regfile_pipe.sv
// -----------------------------------------------------------------------------
// decode_regfile_pipe
//
// Decode stage of the lightbike CPU pipeline, between fetch and execute.
// Contains the register file (2 combinational read ports with write-through
// bypass, 1 writeback port), the instruction field decoder and a one-cycle
// output register with stall/flush control.
//
// Ports
//   clock : sole clock, all state updates on posedge
//   reset : asynchronous, active-low
//   bus   : decode_regfile_pipe_if.slave (instruction in, writeback,
//           registered decode outputs, perf counters)
//
// Parameters
//   DATA_W    operand/register width
//   NUM_REGS  implemented registers (2..32); higher indices read 0, writes
//             to them are dropped
//   RA_IDX    link register written by jal
//   RSTAT_IDX status register read by bex, written by setx
//
// Optional feature
//   Define PERF_CNT_EN to build perf_issued / perf_stalled counters.
//   Without it both outputs are tied to zero and no counter flops exist.
//
// Output register priority: reset > flush > stall > load.
// -----------------------------------------------------------------------------
module decode_regfile_pipe #(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 32,
    parameter int RA_IDX    = 31,
    parameter int RSTAT_IDX = 30
) (
    input  logic                    clock,
    input  logic                    reset,
    decode_regfile_pipe_if.slave    bus
);

    // Opcodes
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] LP_RA    = 5'(RA_IDX);
    localparam logic [4:0] LP_RSTAT = 5'(RSTAT_IDX);

    // An index addresses a real register only if it is nonzero and implemented.
    function automatic logic in_range(input logic [4:0] idx);
        return (idx != 5'd0) && (int'({27'd0, idx}) < NUM_REGS);
    endfunction

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [4:0]  w_op;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_shamt;
    logic [4:0]  w_alu;
    logic [16:0] w_imm;
    logic [26:0] w_tgt;

    assign w_op    = bus.instruction[31:27];
    assign w_rd    = bus.instruction[26:22];
    assign w_rs    = bus.instruction[21:17];
    assign w_rt    = bus.instruction[16:12];
    assign w_shamt = bus.instruction[11:7];
    assign w_alu   = bus.instruction[6:2];
    assign w_imm   = bus.instruction[16:0];
    assign w_tgt   = bus.instruction[26:0];

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    // All 32 slots are declared so any 5-bit index is legal; slots beyond
    // NUM_REGS are never written and stay at their reset value.
    logic [DATA_W-1:0] r_regs [0:31];
    logic              w_we;

    assign w_we = bus.wb_en && in_range(bus.wb_rd);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[bus.wb_rd] <= bus.wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Read address selection
    // ------------------------------------------------------------------
    logic [4:0] w_addr_a;
    logic [4:0] w_addr_b;

    always_comb begin
        w_addr_a = w_rs;
        if (w_op == OP_BEX) begin
            w_addr_a = LP_RSTAT;
        end

        // Stores, branches and jr compare/forward the register named in rd.
        w_addr_b = w_rt;
        case (w_op)
            OP_SW, OP_BNE, OP_BLT, OP_JR: w_addr_b = w_rd;
            default:                      w_addr_b = w_rt;
        endcase
    end

    // ------------------------------------------------------------------
    // Combinational reads with write-through bypass
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_rdata_a;
    logic [DATA_W-1:0] w_rdata_b;

    always_comb begin
        w_rdata_a = '0;
        if (in_range(w_addr_a)) begin
            if (w_we && (bus.wb_rd == w_addr_a)) begin
                w_rdata_a = bus.wb_data;
            end else begin
                w_rdata_a = r_regs[w_addr_a];
            end
        end

        w_rdata_b = '0;
        if (in_range(w_addr_b)) begin
            if (w_we && (bus.wb_rd == w_addr_b)) begin
                w_rdata_b = bus.wb_data;
            end else begin
                w_rdata_b = r_regs[w_addr_b];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic       w_j1en;
    logic       w_j2en;
    logic       w_ren;
    logic       w_men;
    logic       w_ben;
    logic       w_exen;
    logic [4:0] w_aluop;
    logic [4:0] w_rd_out;

    always_comb begin
        w_j1en   = 1'b0;
        w_j2en   = 1'b0;
        w_ren    = 1'b0;
        w_men    = 1'b0;
        w_ben    = 1'b0;
        w_exen   = 1'b0;
        w_aluop  = 5'd0;
        w_rd_out = w_rd;

        case (w_op)
            OP_RTYPE: begin
                w_ren   = 1'b1;
                w_aluop = w_alu;
            end
            OP_ADDI, OP_LW: begin
                w_ren   = 1'b1;
                w_aluop = 5'd0;
            end
            OP_SW: begin
                w_men   = 1'b1;
                w_aluop = 5'd0;
            end
            OP_BNE, OP_BLT: begin
                // Branches subtract to compare.
                w_ben   = 1'b1;
                w_aluop = 5'd1;
            end
            OP_J: begin
                w_j1en = 1'b1;
            end
            OP_JAL: begin
                w_j1en   = 1'b1;
                w_ren    = 1'b1;
                w_rd_out = LP_RA;
            end
            OP_JR: begin
                w_j2en = 1'b1;
            end
            OP_SETX: begin
                w_ren    = 1'b1;
                w_rd_out = LP_RSTAT;
            end
            OP_BEX: begin
                w_exen = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output pipeline register
    // ------------------------------------------------------------------
    logic              r_out_valid;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_j1en;
    logic              r_j2en;
    logic              r_ren;
    logic              r_men;
    logic              r_ben;
    logic              r_exen;
    logic [4:0]        r_aluop;
    logic [4:0]        r_shamt;
    logic [4:0]        r_rd_out;
    logic [16:0]       r_imm;
    logic [26:0]       r_tgt;
    // Register indices that produced the held A/B, so a writeback during a
    // stall can refresh them.
    logic [4:0]        r_src_a;
    logic [4:0]        r_src_b;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_j1en      <= 1'b0;
            r_j2en      <= 1'b0;
            r_ren       <= 1'b0;
            r_men       <= 1'b0;
            r_ben       <= 1'b0;
            r_exen      <= 1'b0;
            r_aluop     <= 5'd0;
            r_shamt     <= 5'd0;
            r_rd_out    <= 5'd0;
            r_imm       <= 17'd0;
            r_tgt       <= 27'd0;
            r_src_a     <= 5'd0;
            r_src_b     <= 5'd0;
        end else if (bus.flush) begin
            // Bubble: kill validity and every side-effecting enable; data
            // fields simply hold.
            r_out_valid <= 1'b0;
            r_j1en      <= 1'b0;
            r_j2en      <= 1'b0;
            r_ren       <= 1'b0;
            r_men       <= 1'b0;
            r_ben       <= 1'b0;
            r_exen      <= 1'b0;
        end else if (bus.stall) begin
            // w_we already excludes r0 and unimplemented indices, so a match
            // here always names a real register.
            if (w_we && (bus.wb_rd == r_src_a)) begin
                r_a <= bus.wb_data;
            end
            if (w_we && (bus.wb_rd == r_src_b)) begin
                r_b <= bus.wb_data;
            end
        end else begin
            r_out_valid <= bus.in_valid;
            r_a         <= w_rdata_a;
            r_b         <= w_rdata_b;
            r_j1en      <= w_j1en && bus.in_valid;
            r_j2en      <= w_j2en && bus.in_valid;
            r_ren       <= w_ren  && bus.in_valid;
            r_men       <= w_men  && bus.in_valid;
            r_ben       <= w_ben  && bus.in_valid;
            r_exen      <= w_exen && bus.in_valid;
            r_aluop     <= w_aluop;
            r_shamt     <= w_shamt;
            r_rd_out    <= w_rd_out;
            r_imm       <= w_imm;
            r_tgt       <= w_tgt;
            r_src_a     <= w_addr_a;
            r_src_b     <= w_addr_b;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.A         = r_a;
    assign bus.B         = r_b;
    assign bus.j1en      = r_j1en;
    assign bus.j2en      = r_j2en;
    assign bus.ren_out   = r_ren;
    assign bus.men       = r_men;
    assign bus.ben       = r_ben;
    assign bus.exen      = r_exen;
    assign bus.aluop     = r_aluop;
    assign bus.shamt     = r_shamt;
    assign bus.rd_out    = r_rd_out;
    assign bus.immediate = r_imm;
    assign bus.target    = r_tgt;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef PERF_CNT_EN
    logic [31:0] r_perf_issued;
    logic [31:0] r_perf_stalled;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_perf_issued  <= 32'd0;
            r_perf_stalled <= 32'd0;
        end else begin
            if (!bus.flush && !bus.stall && bus.in_valid) begin
                r_perf_issued <= r_perf_issued + 32'd1;
            end
            // Counts cycles a live instruction is held, not idle stalls.
            if (bus.stall && r_out_valid) begin
                r_perf_stalled <= r_perf_stalled + 32'd1;
            end
        end
    end

    assign bus.perf_issued  = r_perf_issued;
    assign bus.perf_stalled = r_perf_stalled;
`else
    assign bus.perf_issued  = 32'd0;
    assign bus.perf_stalled = 32'd0;
`endif

endmodule

// File: tb/tb_decode_regfile_pipe.sv
module tb_decode_regfile_pipe;

  logic clock;
  logic reset;

  decode_regfile_pipe_if #(.DATA_W(32)) bus32 ();
  decode_regfile_pipe_if #(.DATA_W(32)) bus16 ();

  decode_regfile_pipe #(.DATA_W(32), .NUM_REGS(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus32)
  );

  decode_regfile_pipe #(.DATA_W(32), .NUM_REGS(16)) dut16 (
    .clock (clock),
    .reset (reset),
    .bus   (bus16)
  );

  // The 16-register instance sees exactly the same stimulus.
  assign bus16.in_valid    = bus32.in_valid;
  assign bus16.instruction = bus32.instruction;
  assign bus16.stall       = bus32.stall;
  assign bus16.flush       = bus32.flush;
  assign bus16.wb_en       = bus32.wb_en;
  assign bus16.wb_rd       = bus32.wb_rd;
  assign bus16.wb_data     = bus32.wb_data;

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    exp_q.push_back(exp);
    n_cmp++;
    if (act !== exp_q.pop_front()) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  localparam logic [5:0] EN_J1 = 6'b100000;
  localparam logic [5:0] EN_J2 = 6'b010000;
  localparam logic [5:0] EN_RN = 6'b001000;
  localparam logic [5:0] EN_MN = 6'b000100;
  localparam logic [5:0] EN_BN = 6'b000010;
  localparam logic [5:0] EN_EX = 6'b000001;

  function automatic logic [5:0] en_vec();
    return {bus32.j1en, bus32.j2en, bus32.ren_out, bus32.men, bus32.ben, bus32.exen};
  endfunction

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] sh, input logic [4:0] alu);
    return {op, rd, rs, rt, sh, alu, 2'b00};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] op, input logic [26:0] tgt);
    return {op, tgt};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus32.in_valid    = 1'b0;
    bus32.instruction = 32'd0;
    bus32.stall       = 1'b0;
    bus32.flush       = 1'b0;
    bus32.wb_en       = 1'b0;
    bus32.wb_rd       = 5'd0;
    bus32.wb_data     = 32'd0;
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
    idle_inputs();
    bus32.wb_en   = 1'b1;
    bus32.wb_rd   = rd;
    bus32.wb_data = data;
    tick();
    bus32.wb_en   = 1'b0;
  endtask

  task automatic issue(input logic [31:0] instr);
    idle_inputs();
    bus32.in_valid    = 1'b1;
    bus32.instruction = instr;
    tick();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] instr;
    logic        vin;
    logic        chk_a;
    logic [31:0] a;
    logic        chk_b;
    logic [31:0] b;
    logic [5:0]  en;
    logic [4:0]  alu;
    logic [4:0]  rd;
    logic        ov;
  } vec_t;

  vec_t vt[14];

  initial begin
    // Registers are preloaded with r_k = 0x100 + k before the table runs.
    vt[0]  = '{enc_r(5'd0, 5'd3, 5'd1, 5'd2, 5'd4, 5'd3),   1'b1, 1'b1, 32'h101, 1'b1, 32'h102, EN_RN,         5'd3, 5'd3,  1'b1};
    vt[1]  = '{enc_r(5'd0, 5'd9, 5'd0, 5'd31, 5'd0, 5'd1),  1'b1, 1'b1, 32'h000, 1'b1, 32'h11F, EN_RN,         5'd1, 5'd9,  1'b1};
    vt[2]  = '{enc_i(5'd5, 5'd6, 5'd7, 17'h00123),          1'b1, 1'b1, 32'h107, 1'b0, 32'h0,   EN_RN,         5'd0, 5'd6,  1'b1};
    vt[3]  = '{enc_i(5'd8, 5'd10, 5'd11, 17'h1FFFF),        1'b1, 1'b1, 32'h10B, 1'b0, 32'h0,   EN_RN,         5'd0, 5'd10, 1'b1};
    vt[4]  = '{enc_i(5'd7, 5'd12, 5'd13, 17'h00004),        1'b1, 1'b1, 32'h10D, 1'b1, 32'h10C, EN_MN,         5'd0, 5'd12, 1'b1};
    vt[5]  = '{enc_i(5'd2, 5'd14, 5'd15, 17'h00010),        1'b1, 1'b1, 32'h10F, 1'b1, 32'h10E, EN_BN,         5'd1, 5'd14, 1'b1};
    vt[6]  = '{enc_i(5'd6, 5'd16, 5'd17, 17'h00020),        1'b1, 1'b1, 32'h111, 1'b1, 32'h110, EN_BN,         5'd1, 5'd16, 1'b1};
    vt[7]  = '{enc_i(5'd4, 5'd31, 5'd0, 17'h00000),         1'b1, 1'b1, 32'h000, 1'b1, 32'h11F, EN_J2,         5'd0, 5'd31, 1'b1};
    vt[8]  = '{enc_j(5'd1, 27'h1234567),                    1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   EN_J1,         5'd0, 5'd4,  1'b1};
    vt[9]  = '{enc_j(5'd3, 27'h0000ABC),                    1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   EN_J1 | EN_RN, 5'd0, 5'd31, 1'b1};
    vt[10] = '{enc_j(5'd21, 27'h0000005),                   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   EN_RN,         5'd0, 5'd30, 1'b1};
    vt[11] = '{enc_j(5'd22, 27'h0000007),                   1'b1, 1'b1, 32'h11E, 1'b0, 32'h0,   EN_EX,         5'd0, 5'd0,  1'b1};
    vt[12] = '{enc_r(5'd31, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0),  1'b1, 1'b1, 32'h102, 1'b0, 32'h0,   6'b000000,     5'd0, 5'd1,  1'b1};
    vt[13] = '{enc_r(5'd0, 5'd3, 5'd1, 5'd2, 5'd4, 5'd3),   1'b0, 1'b1, 32'h101, 1'b1, 32'h102, 6'b000000,     5'd3, 5'd3,  1'b0};
  end

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b0;
    idle_inputs();
    repeat (2) tick();

    // Reset state
    check("rst_out_valid", 32'(bus32.out_valid), 32'd0);
    check("rst_A", bus32.A, 32'd0);
    check("rst_B", bus32.B, 32'd0);
    check("rst_en", 32'(en_vec()), 32'd0);
    check("rst_rd_out", 32'(bus32.rd_out), 32'd0);
    check("rst_perf_issued", bus32.perf_issued, 32'd0);
    check("rst_perf_stalled", bus32.perf_stalled, 32'd0);

    reset = 1'b1;
    tick();

    // add r3, r1, r2 after r1=1, r2=2
    wb_write(5'd1, 32'd1);
    wb_write(5'd2, 32'd2);
    issue(enc_r(5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0));
    check("add_A", bus32.A, 32'd1);
    check("add_B", bus32.B, 32'd2);
    check("add_ren", 32'(bus32.ren_out), 32'd1);
    check("add_rd_out", 32'(bus32.rd_out), 32'd3);
    check("add_out_valid", 32'(bus32.out_valid), 32'd1);

    // Same-cycle writeback and read of r5
    idle_inputs();
    bus32.in_valid    = 1'b1;
    bus32.instruction = enc_i(5'd5, 5'd6, 5'd5, 17'h1A5C3);
    bus32.wb_en       = 1'b1;
    bus32.wb_rd       = 5'd5;
    bus32.wb_data     = 32'h0000DEAD;
    tick();
    check("byp_A", bus32.A, 32'h0000DEAD);
    check("byp_aluop", 32'(bus32.aluop), 32'd0);
    check("byp_imm", 32'(bus32.immediate), 32'h1A5C3);

    // r0 is hardwired, also when written in the reading cycle
    wb_write(5'd0, 32'h0000FFFF);
    issue(enc_i(5'd5, 5'd6, 5'd0, 17'h0));
    check("r0_A", bus32.A, 32'd0);
    idle_inputs();
    bus32.in_valid    = 1'b1;
    bus32.instruction = enc_i(5'd5, 5'd6, 5'd0, 17'h0);
    bus32.wb_en       = 1'b1;
    bus32.wb_rd       = 5'd0;
    bus32.wb_data     = 32'h0000FFFF;
    tick();
    check("r0_byp_A", bus32.A, 32'd0);

    // r20 exists only in the 32-register instance
    wb_write(5'd20, 32'd7);
    issue(enc_i(5'd5, 5'd6, 5'd20, 17'h0));
    check("r20_A_n32", bus32.A, 32'd7);
    check("r20_A_n16", bus16.A, 32'd0);

    // Stall hold with operand refresh (r4 = 0, r2 = 2)
    issue(enc_r(5'd0, 5'd8, 5'd4, 5'd2, 5'd0, 5'd0));
    check("stl_load_A", bus32.A, 32'd0);
    check("stl_load_B", bus32.B, 32'd2);
    idle_inputs();
    bus32.stall       = 1'b1;
    bus32.in_valid    = 1'b1;
    bus32.instruction = enc_r(5'd0, 5'd9, 5'd1, 5'd1, 5'd0, 5'd0);
    tick();
    check("stl_hold_rd", 32'(bus32.rd_out), 32'd8);
    check("stl_hold_B", bus32.B, 32'd2);
    bus32.wb_en   = 1'b1;
    bus32.wb_rd   = 5'd4;
    bus32.wb_data = 32'h55;
    tick();
    check("stl_ref_A", bus32.A, 32'h55);
    check("stl_ref_B", bus32.B, 32'd2);
    check("stl_ref_rd", 32'(bus32.rd_out), 32'd8);
    check("stl_ref_valid", 32'(bus32.out_valid), 32'd1);
    bus32.wb_rd   = 5'd2;
    bus32.wb_data = 32'h77;
    tick();
    check("stl_refb_A", bus32.A, 32'h55);
    check("stl_refb_B", bus32.B, 32'h77);
    bus32.wb_en = 1'b0;
    bus32.stall = 1'b0;
    tick();
    check("stl_rel_A", bus32.A, 32'd1);
    check("stl_rel_B", bus32.B, 32'd1);
    check("stl_rel_rd", 32'(bus32.rd_out), 32'd9);

    // Flush overrides stall
    bus32.stall = 1'b1;
    bus32.flush = 1'b1;
    tick();
    check("flush_valid", 32'(bus32.out_valid), 32'd0);
    check("flush_en", 32'(en_vec()), 32'd0);

    // Preload r_k = 0x100 + k and run the table
    for (int k = 1; k < 32; k++) wb_write(5'(k), 32'h100 + 32'(k));
    for (int i = 0; i < 14; i++) begin
      idle_inputs();
      bus32.in_valid    = vt[i].vin;
      bus32.instruction = vt[i].instr;
      tick();
      check($sformatf("v%0d_valid", i), 32'(bus32.out_valid), 32'(vt[i].ov));
      check($sformatf("v%0d_en", i), 32'(en_vec()), 32'(vt[i].en));
      check($sformatf("v%0d_aluop", i), 32'(bus32.aluop), 32'(vt[i].alu));
      check($sformatf("v%0d_rd_out", i), 32'(bus32.rd_out), 32'(vt[i].rd));
      check($sformatf("v%0d_shamt", i), 32'(bus32.shamt), 32'(vt[i].instr[11:7]));
      check($sformatf("v%0d_imm", i), 32'(bus32.immediate), 32'(vt[i].instr[16:0]));
      check($sformatf("v%0d_tgt", i), 32'(bus32.target), 32'(vt[i].instr[26:0]));
      if (vt[i].chk_a) check($sformatf("v%0d_A", i), bus32.A, vt[i].a);
      if (vt[i].chk_b) check($sformatf("v%0d_B", i), bus32.B, vt[i].b);
    end

    // Performance counters: 3 issues, 2 stalled cycles, 1 flush
    do_reset();
    issue(enc_r(5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0));
    issue(enc_r(5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0));
    bus32.stall = 1'b1;
    repeat (2) tick();
    bus32.stall = 1'b0;
    bus32.flush = 1'b1;
    tick();
    check("pf_flush_valid", 32'(bus32.out_valid), 32'd0);
    issue(enc_r(5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0));
    idle_inputs();
    tick();
`ifdef PERF_CNT_EN
    check("perf_issued", bus32.perf_issued, 32'd3);
    check("perf_stalled", bus32.perf_stalled, 32'd2);
`else
    check("perf_issued_off", bus32.perf_issued, 32'd0);
    check("perf_stalled_off", bus32.perf_stalled, 32'd0);
`endif

    // Reset asserted mid-stall clears everything
    issue(enc_r(5'd0, 5'd3, 5'd1, 5'd2, 5'd0, 5'd0));
    bus32.stall = 1'b1;
    tick();
    check("mid_pre_valid", 32'(bus32.out_valid), 32'd1);
    #1;
    reset = 1'b0;
    #2;
    check("mid_valid", 32'(bus32.out_valid), 32'd0);
    check("mid_en", 32'(en_vec()), 32'd0);
    check("mid_rd_out", 32'(bus32.rd_out), 32'd0);
    check("mid_perf_issued", bus32.perf_issued, 32'd0);
    check("mid_perf_stalled", bus32.perf_stalled, 32'd0);
    reset = 1'b1;
    wb_write(5'd1, 32'h1234);
    issue(enc_r(5'd0, 5'd7, 5'd1, 5'd0, 5'd0, 5'd2));
    check("post_rst_valid", 32'(bus32.out_valid), 32'd1);
    check("post_rst_A", bus32.A, 32'h1234);
    check("post_rst_rd", 32'(bus32.rd_out), 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
